// File: rtl/video_rx_pkg.sv
// Shared types for the video timing receiver: counter width, FSM states,
// measurement record and the output pixel pipeline record.
package video_rx_pkg;

   localparam int CW = 12;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } vrx_state_e;

   typedef struct packed {
      logic [CW-1:0] h_total;
      logic [CW-1:0] h_active;
      logic [CW-1:0] v_total;
      logic [CW-1:0] v_active;
   } vrx_meas_t;

   typedef struct packed {
      logic          valid;
      logic          sof;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [7:0]    r;
      logic [7:0]    g;
      logic [7:0]    b;
   } vrx_pix_t;

   // Counters stick at full scale instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/video_timing_receiver_if.sv
// Video input bus plus captured-pixel / measurement outputs.
interface video_timing_receiver_if;

   logic                         i_pix_en;
   logic                         i_hsync;
   logic                         i_vsync;
   logic                         i_de;
   logic [7:0]                   i_r;
   logic [7:0]                   i_g;
   logic [7:0]                   i_b;
   logic [7:0]                   o_r;
   logic [7:0]                   o_g;
   logic [7:0]                   o_b;
   logic [video_rx_pkg::CW-1:0]  o_x;
   logic [video_rx_pkg::CW-1:0]  o_y;
   logic                         o_valid;
   logic                         o_sof;
   logic [video_rx_pkg::CW-1:0]  o_h_total;
   logic [video_rx_pkg::CW-1:0]  o_h_active;
   logic [video_rx_pkg::CW-1:0]  o_v_total;
   logic [video_rx_pkg::CW-1:0]  o_v_active;
   logic                         o_locked;
   logic                         o_err;

   // Video source side
   modport master (
      output i_pix_en, i_hsync, i_vsync, i_de, i_r, i_g, i_b,
      input  o_r, o_g, o_b, o_x, o_y, o_valid, o_sof,
             o_h_total, o_h_active, o_v_total, o_v_active, o_locked, o_err
   );

   // Receiver side
   modport slave (
      input  i_pix_en, i_hsync, i_vsync, i_de, i_r, i_g, i_b,
      output o_r, o_g, o_b, o_x, o_y, o_valid, o_sof,
             o_h_total, o_h_active, o_v_total, o_v_active, o_locked, o_err
   );

endinterface

// File: rtl/video_timing_measure.sv
// Edge detection, line/pixel/frame counters and measurement latches.
// Sync inputs are normalised to active-high so the history resets to 0.
module video_timing_measure
   import video_rx_pkg::*;
#(
   parameter logic SYNC_POL = 1'b1,
   parameter int   WDOG_PIX = 4095
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_en,
   input  logic          hsync,
   input  logic          vsync,
   input  logic          de,
   output logic          vs_edge,
   output logic          wdog,
   output logic          pix_de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output vrx_meas_t     meas_new,
   output vrx_meas_t     meas
);

   localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_PIX - 1);

   logic          hs_act, vs_act, hs_lead, de_lead, de_trail;
   logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
   logic [CW-1:0] hcnt_q, hcnt_d, x_q, x_d;
   logic [CW-1:0] hs_lines_q, hs_lines_d, hs_lines_nx;
   logic [CW-1:0] de_lines_q, de_lines_d, de_lines_nx;
   logic [CW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
   vrx_meas_t     meas_q, meas_d;

   // Edge detection, counter advance and latch selection for one strobe
   always_comb begin
      hs_act   = (hsync == SYNC_POL);
      vs_act   = (vsync == SYNC_POL);
      hs_lead  = pix_en &  hs_act & ~hs_prev_q;
      vs_edge  = pix_en &  vs_act & ~vs_prev_q;
      de_lead  = pix_en &  de     & ~de_prev_q;
      de_trail = pix_en & ~de     &  de_prev_q;
      // fires once, on the strobe where hcnt would reach WDOG_PIX
      wdog     = pix_en & ~hs_lead & (hcnt_q == WDOG_LAST);
      pix_de   = pix_en & de;

      hs_prev_d = hs_prev_q;
      vs_prev_d = vs_prev_q;
      de_prev_d = de_prev_q;
      hcnt_d    = hcnt_q;
      x_d       = x_q;
      if (pix_en) begin
         hs_prev_d = hs_act;
         vs_prev_d = vs_act;
         de_prev_d = de;
         hcnt_d    = hs_lead ? '0 : sat_inc(hcnt_q);
         x_d       = de_lead ? '0 : sat_inc(x_q);
      end

      h_total_d   = hs_lead  ? sat_inc(hcnt_q)     : h_total_q;
      h_active_d  = de_trail ? sat_inc(x_q)        : h_active_q;
      // an hsync edge coincident with vsync still belongs to the ending frame
      hs_lines_nx = hs_lead  ? sat_inc(hs_lines_q) : hs_lines_q;
      de_lines_nx = de_trail ? sat_inc(de_lines_q) : de_lines_q;

      meas_new.h_total  = h_total_d;
      meas_new.h_active = h_active_d;
      meas_new.v_total  = hs_lines_nx;
      meas_new.v_active = de_lines_nx;

      meas_d     = meas_q;
      hs_lines_d = hs_lines_nx;
      de_lines_d = de_lines_nx;
      if (vs_edge) begin
         meas_d     = meas_new;
         hs_lines_d = '0;
         de_lines_d = '0;
      end

      x    = x_d;
      y    = de_lines_q;
      meas = meas_q;
   end

   // Counter, history and measurement state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_prev_q  <= 1'b0;
         vs_prev_q  <= 1'b0;
         de_prev_q  <= 1'b0;
         hcnt_q     <= '0;
         x_q        <= '0;
         hs_lines_q <= '0;
         de_lines_q <= '0;
         h_total_q  <= '0;
         h_active_q <= '0;
         meas_q     <= '0;
      end else begin
         hs_prev_q  <= hs_prev_d;
         vs_prev_q  <= vs_prev_d;
         de_prev_q  <= de_prev_d;
         hcnt_q     <= hcnt_d;
         x_q        <= x_d;
         hs_lines_q <= hs_lines_d;
         de_lines_q <= de_lines_d;
         h_total_q  <= h_total_d;
         h_active_q <= h_active_d;
         meas_q     <= meas_d;
      end
   end

endmodule

// File: rtl/video_timing_receiver.sv
// Video timing receiver: lock FSM over per-frame measurements and a
// two-stage capture pipeline for active pixels.
module video_timing_receiver
   import video_rx_pkg::*;
#(
   parameter logic SYNC_POL    = 1'b1,
   parameter int   LOCK_FRAMES = 2,
   parameter int   WDOG_PIX    = 4095
) (
   input  logic                    clk,
   input  logic                    reset,
   video_timing_receiver_if.slave  vif
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

   logic          vs_edge, wdog, pix_de, meas_eq;
   logic [CW-1:0] x, y;
   vrx_meas_t     meas_new, meas;

   vrx_state_e    state_q, state_d;
   logic [3:0]    match_q, match_d;
   logic          first_q, first_d, err_q, err_d;
   vrx_meas_t     ref_q, ref_d;
   vrx_pix_t      s1_q, s1_d, s2_q;

   video_timing_measure #(
      .SYNC_POL (SYNC_POL),
      .WDOG_PIX (WDOG_PIX)
   ) u_measure (
      .clk      (clk),
      .reset    (reset),
      .pix_en   (vif.i_pix_en),
      .hsync    (vif.i_hsync),
      .vsync    (vif.i_vsync),
      .de       (vif.i_de),
      .vs_edge  (vs_edge),
      .wdog     (wdog),
      .pix_de   (pix_de),
      .x        (x),
      .y        (y),
      .meas_new (meas_new),
      .meas     (meas)
   );

   // Lock FSM: compare each frame's measurements against a reference.
   // Every entry into TRACK re-acquires the reference from the next frame.
   always_comb begin
      state_d = state_q;
      match_d = match_q;
      first_d = first_q;
      ref_d   = ref_q;
      err_d   = 1'b0;
      meas_eq = (meas_new == ref_q);
      if (wdog) begin
         state_d = ST_SEARCH;
         match_d = '0;
         first_d = 1'b1;
         err_d   = (state_q == ST_LOCKED);
      end else if (vs_edge) begin
         case (state_q)
            ST_SEARCH: begin
               state_d = ST_TRACK;
               match_d = '0;
               first_d = 1'b1;
            end
            ST_TRACK: begin
               if (first_q || !meas_eq) begin
                  ref_d   = meas_new;
                  match_d = '0;
                  first_d = 1'b0;
               end else begin
                  match_d = match_q + 4'd1;
                  if (match_d == LOCK_N) state_d = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (!meas_eq) begin
                  state_d = ST_TRACK;
                  match_d = '0;
                  first_d = 1'b1;
                  err_d   = 1'b1;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end
   end

   // Stage 1 capture: only in-window active pixels while locked; zero otherwise
   always_comb begin
      s1_d = '0;
      if (pix_de && (state_q == ST_LOCKED) &&
          (x < meas.h_active) && (y < meas.v_active)) begin
         s1_d.valid = 1'b1;
         s1_d.sof   = (x == '0) && (y == '0);
         s1_d.x     = x;
         s1_d.y     = y;
         s1_d.r     = vif.i_r;
         s1_d.g     = vif.i_g;
         s1_d.b     = vif.i_b;
      end
   end

   // FSM state, reference and pixel pipeline registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_SEARCH;
         match_q <= '0;
         first_q <= 1'b1;
         ref_q   <= '0;
         err_q   <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         first_q <= first_d;
         ref_q   <= ref_d;
         err_q   <= err_d;
         s1_q    <= s1_d;
         s2_q    <= s1_q;
      end
   end

   assign vif.o_valid    = s2_q.valid;
   assign vif.o_sof      = s2_q.sof;
   assign vif.o_x        = s2_q.x;
   assign vif.o_y        = s2_q.y;
   assign vif.o_r        = s2_q.r;
   assign vif.o_g        = s2_q.g;
   assign vif.o_b        = s2_q.b;
   assign vif.o_h_total  = meas.h_total;
   assign vif.o_h_active = meas.h_active;
   assign vif.o_v_total  = meas.v_total;
   assign vif.o_v_active = meas.v_active;
   assign vif.o_locked   = (state_q == ST_LOCKED);
   assign vif.o_err      = err_q;

endmodule

// File: tb/tb_video_timing_receiver.sv
// Scoreboard bench: frame generator pushes expected pixels, a negedge
// monitor pops and compares. A second instance runs inverted sync polarity.
module tb_video_timing_receiver;

   typedef struct {
      int         x;
      int         y;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       sof;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   err_cnt = 0, errn_cnt = 0;
   int   val_cnt = 0, valn_cnt = 0, sof_cnt = 0;
   exp_t q[$];
   exp_t mon_e;

   video_timing_receiver_if vif();
   video_timing_receiver_if vifn();

   video_timing_receiver #(.SYNC_POL(1'b1), .LOCK_FRAMES(2), .WDOG_PIX(4095)) dut (
      .clk(clk), .reset(reset), .vif(vif));
   video_timing_receiver #(.SYNC_POL(1'b0), .LOCK_FRAMES(2), .WDOG_PIX(4095)) dut_n (
      .clk(clk), .reset(reset), .vif(vifn));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every o_valid must match the oldest expectation, 2 clk after its strobe
   always @(negedge clk) begin
      if (vif.o_err)    err_cnt++;
      if (vifn.o_err)   errn_cnt++;
      if (vifn.o_valid) valn_cnt++;
      if (vif.o_valid) begin
         val_cnt++;
         if (vif.o_sof) sof_cnt++;
         if (q.size() == 0) chk("unexpected_valid", int'(vif.o_valid), 0);
         else begin
            mon_e = q.pop_front();
            chk("pix_x",   int'(vif.o_x),   mon_e.x);
            chk("pix_y",   int'(vif.o_y),   mon_e.y);
            chk("pix_r",   int'(vif.o_r),   int'(mon_e.r));
            chk("pix_g",   int'(vif.o_g),   int'(mon_e.g));
            chk("pix_b",   int'(vif.o_b),   int'(mon_e.b));
            chk("pix_sof", int'(vif.o_sof), int'(mon_e.sof));
            chk("latency", cyc,             mon_e.cyc);
         end
      end
   end

   task automatic idle_inputs();
      vif.i_pix_en = 1'b0; vif.i_hsync = 1'b0; vif.i_vsync = 1'b0; vif.i_de = 1'b0;
      vif.i_r = '0; vif.i_g = '0; vif.i_b = '0;
      vifn.i_pix_en = 1'b0; vifn.i_hsync = 1'b1; vifn.i_vsync = 1'b1; vifn.i_de = 1'b0;
      vifn.i_r = '0; vifn.i_g = '0; vifn.i_b = '0;
   endtask

   // One strobe cycle with real data, then one non-strobe cycle of junk
   task automatic drive_sample(input logic hs, input logic vs, input logic de,
                               input int x, input int y, input bit push);
      logic [7:0] r, g, b;
      r = 8'(x); g = 8'(y); b = 8'(x) ^ 8'hA5;
      @(posedge clk); #1;
      vif.i_pix_en  = 1'b1; vif.i_hsync  = hs;  vif.i_vsync  = vs;  vif.i_de  = de;
      vif.i_r  = r; vif.i_g  = g; vif.i_b  = b;
      vifn.i_pix_en = 1'b1; vifn.i_hsync = ~hs; vifn.i_vsync = ~vs; vifn.i_de = de;
      vifn.i_r = r; vifn.i_g = g; vifn.i_b = b;
      if (push) q.push_back('{x, y, r, g, b, (x == 0 && y == 0), cyc + 2});
      @(posedge clk); #1;
      vif.i_pix_en  = 1'b0; vif.i_hsync  = 1'($urandom); vif.i_vsync  = 1'($urandom);
      vif.i_de  = 1'($urandom); vif.i_r  = 8'($urandom);
      vifn.i_pix_en = 1'b0; vifn.i_hsync = 1'($urandom); vifn.i_vsync = 1'($urandom);
      vifn.i_de = 1'($urandom); vifn.i_r = 8'($urandom);
   endtask

   // Line: sync 0..2, bp 3..6, active 7..22, fp to htot-1. Frame: vsync lines 0..1,
   // active lines 4..11, 13 lines. stop_at >= 0 aborts after that many samples.
   task automatic send_frame(input int htot, input bit pix, input int stop_at);
      int n;
      bit de;
      n = 0;
      for (int l = 0; l < 13; l++) begin
         for (int h = 0; h < htot; h++) begin
            if (stop_at >= 0 && n == stop_at) return;
            de = (l >= 4) && (l < 12) && (h >= 7) && (h < 23);
            drive_sample(h < 3, l < 2, de, h - 7, l - 4, pix && de);
            n++;
         end
      end
   endtask

   task automatic run_frame(input string tag, input int htot, input bit pix, input bit lock_exp);
      int v0, vn0, s0;
      v0 = val_cnt; vn0 = valn_cnt; s0 = sof_cnt;
      send_frame(htot, pix, -1);
      chk({tag, "_locked"},   int'(vif.o_locked),  int'(lock_exp));
      chk({tag, "_locked_n"}, int'(vifn.o_locked), int'(lock_exp));
      chk({tag, "_pixels"},   val_cnt - v0,        pix ? 128 : 0);
      chk({tag, "_pixels_n"}, valn_cnt - vn0,      pix ? 128 : 0);
      chk({tag, "_sof"},      sof_cnt - s0,        pix ? 1 : 0);
   endtask

   task automatic chk_meas(input string tag, input int ht, input int ha, input int vt, input int va);
      chk({tag, "_h_total"},    int'(vif.o_h_total),   ht);
      chk({tag, "_h_active"},   int'(vif.o_h_active),  ha);
      chk({tag, "_v_total"},    int'(vif.o_v_total),   vt);
      chk({tag, "_v_active"},   int'(vif.o_v_active),  va);
      chk({tag, "_h_total_n"},  int'(vifn.o_h_total),  ht);
      chk({tag, "_h_active_n"}, int'(vifn.o_h_active), ha);
      chk({tag, "_v_total_n"},  int'(vifn.o_v_total),  vt);
      chk({tag, "_v_active_n"}, int'(vifn.o_v_active), va);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_locked"},   int'(vif.o_locked),  0);
      chk({tag, "_err"},      int'(vif.o_err),     0);
      chk({tag, "_valid"},    int'(vif.o_valid),   0);
      chk({tag, "_sof"},      int'(vif.o_sof),     0);
      chk({tag, "_x"},        int'(vif.o_x),       0);
      chk({tag, "_y"},        int'(vif.o_y),       0);
      chk({tag, "_rgb"},      int'({vif.o_r, vif.o_g, vif.o_b}), 0);
      chk({tag, "_locked_n"}, int'(vifn.o_locked), 0);
      chk({tag, "_valid_n"},  int'(vifn.o_valid),  0);
      chk_meas(tag, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      repeat (4) @(posedge clk);
      #1;
      chk_zero("reset");
      reset = 1'b0;

      // Acquisition: edge1 -> TRACK, edge2 reference, edges 3/4 match -> lock
      run_frame("a1", 25, 0, 0);
      run_frame("a2", 25, 0, 0);
      run_frame("a3", 25, 0, 0);
      run_frame("a4", 25, 1, 1);
      chk_meas("a4", 25, 16, 13, 8);
      run_frame("a5", 25, 1, 1);
      chk("a_err", err_cnt, 0);

      // One frame of 26-sample lines: mismatch seen at the following edge
      run_frame("b6", 26, 1, 1);
      run_frame("b7", 25, 0, 0);
      chk("b7_err", err_cnt, 1);
      chk("b7_err_n", errn_cnt, 1);
      chk("b7_h_total", int'(vif.o_h_total), 26);
      run_frame("b8", 25, 0, 0);
      chk("b8_h_total", int'(vif.o_h_total), 25);
      run_frame("b9", 25, 0, 0);
      run_frame("b10", 25, 1, 1);
      chk("b_err", err_cnt, 1);

      // Watchdog: hsync inactive for more than 4095 strobes
      for (int i = 0; i < 4100; i++) drive_sample(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      chk("wd_err", err_cnt, 2);
      chk("wd_err_n", errn_cnt, 2);
      chk("wd_locked", int'(vif.o_locked), 0);
      chk("wd_locked_n", int'(vifn.o_locked), 0);
      run_frame("c1", 25, 0, 0);
      run_frame("c2", 25, 0, 0);
      run_frame("c3", 25, 0, 0);
      run_frame("c4", 25, 1, 1);
      chk_meas("c4", 25, 16, 13, 8);

      // Asynchronous reset mid-line while locked
      send_frame(25, 1, 60);
      chk("pre_rst_locked", int'(vif.o_locked), 1);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk_zero("mid_rst");
      chk("mid_rst_queue", q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      run_frame("d1", 25, 0, 0);
      run_frame("d2", 25, 0, 0);
      run_frame("d3", 25, 0, 0);
      run_frame("d4", 25, 1, 1);
      chk_meas("d4", 25, 16, 13, 8);
      chk("final_err", err_cnt, 2);
      chk("final_err_n", errn_cnt, 2);

      repeat (4) @(posedge clk);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
